id_ex_forward_stage: RTL and testbench
======================================

// Module: id_ex_forward_stage
// PURPOSE
//   ID/EX pipeline register with an integrated forwarding unit for the pipelined CPU.
//   Captures decoded operands, register numbers and write-enable from ID, then presents them to EX.
//   Generates the 2-bit selects that drive the EX-stage 3-to-1 operand muxes.
//   Encoding: 00 = register-file data, 01 = MEM/WB result, 10 = EX/MEM result.
// PARAMETERS
//   size    32   operand data width in bits
// PORTS
//   clk_i              in   1     clock; all state updates on rising edge
//   rst_i              in   1     reset, synchronous, active-high
//   stall_i            in   1     hold ID/EX contents (hazard stall)
//   flush_i            in   1     load a bubble into ID/EX
//   id_valid_i         in   1     ID slot holds a real instruction
//   id_rs_data_i       in   size  rs operand read from the register file
//   id_rt_data_i       in   size  rt operand read from the register file
//   id_rs_addr_i       in   5     rs register number
//   id_rt_addr_i       in   5     rt register number
//   id_rd_addr_i       in   5     destination register number
//   id_reg_write_i     in   1     instruction writes the register file
//   exmem_reg_write_i  in   1     EX/MEM stage instruction writes the register file
//   exmem_rd_addr_i    in   5     EX/MEM destination register
//   memwb_reg_write_i  in   1     MEM/WB stage instruction writes the register file
//   memwb_rd_addr_i    in   5     MEM/WB destination register
//   ex_valid_o         out  1     EX slot valid
//   ex_rs_data_o       out  size  registered rs data (mux data0 for operand A)
//   ex_rt_data_o       out  size  registered rt data (mux data0 for operand B)
//   ex_rs_addr_o       out  5     registered rs number
//   ex_rt_addr_o       out  5     registered rt number
//   ex_rd_addr_o       out  5     registered rd number
//   ex_reg_write_o     out  1     registered write-enable, gated by valid
//   fwd_a_sel_o        out  2     operand-A mux select
//   fwd_b_sel_o        out  2     operand-B mux select
// BEHAVIOUR
//   Register update priority on each rising clk_i edge:
//     1. rst_i:    all registered outputs <= 0.
//     2. flush_i:  bubble loaded; valid = 0, reg_write = 0, data and addresses = 0. Flush overrides stall.
//     3. stall_i:  all fields hold their values.
//     4. Otherwise: capture all id_* fields.
//   Gating and latency:
//     - ex_reg_write_o = captured id_reg_write_i AND id_valid_i.
//     - Capture-to-output latency is 1 cycle.
//   Select logic: combinational from the registered ex_* fields and the current exmem_*/memwb_* inputs.
//     - sel = 10 if exmem_reg_write_i, exmem_rd_addr_i != 0 and exmem_rd_addr_i == ex_rs_addr_o (or ex_rt_addr_o).
//     - Else sel = 01 if the same conditions hold for memwb_*.
//     - Else sel = 00.
//     - EX/MEM wins when both stages match (youngest value).
//     - Register 0 is never forwarded.
//     - ex_valid_o = 0 forces both selects to 00.
//     - 11 is never driven.
//   Reset mid-operation: the in-flight instruction is discarded and selects go to 00 in the following cycle.
// CONFIGURATION
//   Macro: EX_FWD_COUNT_EN
//   Defined:
//     - Adds output fwd_cnt_o [31:0].
//     - Increments by 1 each cycle in which ex_valid_o = 1, stall_i = 0 and either select is non-zero.
//     - Saturates at 32'hFFFF_FFFF.
//     - Cleared by rst_i.
//   Undefined: the port and the counter do not exist; all other behaviour is identical.
// TESTING
//   T1 reset: rst_i=1 for 2 cycles with id_* nonzero
//      -> all ex_* = 0, fwd_a_sel_o = fwd_b_sel_o = 00.
//   T2 EX/MEM forward:
//      - Stimulus: capture rs=5, rt=6, valid=1; exmem_reg_write=1, exmem_rd=5.
//      - Expected: fwd_a_sel_o = 10, fwd_b_sel_o = 00.
//   T3 priority: ex rs=rt=7; exmem rd=7 and memwb rd=7, both writing
//      -> both selects = 10. Drop exmem_reg_write -> both = 01.
//   T4 $zero: ex rs=0; exmem rd=0 with write=1 -> fwd_a_sel_o = 00.
//   T5 stall/flush: capture data A=32'h1234; next cycle stall_i=1 with new id data
//      -> output still 32'h1234. Then stall_i = flush_i = 1 -> ex_valid_o = 0, selects 00.
//   T6 counter (EX_FWD_COUNT_EN defined): 3 forwarding cycles, 1 of them stalled -> fwd_cnt_o = 2.

Source files
------------

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with forwarding-select generation for the EX operand muxes.
// Optional macro EX_FWD_COUNT_EN adds fwd_cnt_o, a saturating count of forwarding cycles.
module id_ex_forward_stage #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [size-1:0] id_rs_data_i,
    input  logic [size-1:0] id_rt_data_i,
    input  logic [4:0]      id_rs_addr_i,
    input  logic [4:0]      id_rt_addr_i,
    input  logic [4:0]      id_rd_addr_i,
    input  logic            id_reg_write_i,
    input  logic            exmem_reg_write_i,
    input  logic [4:0]      exmem_rd_addr_i,
    input  logic            memwb_reg_write_i,
    input  logic [4:0]      memwb_rd_addr_i,
    output logic            ex_valid_o,
    output logic [size-1:0] ex_rs_data_o,
    output logic [size-1:0] ex_rt_data_o,
    output logic [4:0]      ex_rs_addr_o,
    output logic [4:0]      ex_rt_addr_o,
    output logic [4:0]      ex_rd_addr_o,
    output logic            ex_reg_write_o,
    output logic [1:0]      fwd_a_sel_o,
    output logic [1:0]      fwd_b_sel_o
`ifdef EX_FWD_COUNT_EN
    ,
    output logic [31:0]     fwd_cnt_o
`endif
);

    localparam logic [1:0] SEL_REG   = 2'b00;
    localparam logic [1:0] SEL_MEMWB = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;

    // Flush beats stall so a squashed instruction can never linger in a stalled slot.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            ex_valid_o     <= 1'b0;
            ex_rs_data_o   <= '0;
            ex_rt_data_o   <= '0;
            ex_rs_addr_o   <= '0;
            ex_rt_addr_o   <= '0;
            ex_rd_addr_o   <= '0;
            ex_reg_write_o <= 1'b0;
        end else if (!stall_i) begin
            ex_valid_o     <= id_valid_i;
            ex_rs_data_o   <= id_rs_data_i;
            ex_rt_data_o   <= id_rt_data_i;
            ex_rs_addr_o   <= id_rs_addr_i;
            ex_rt_addr_o   <= id_rt_addr_i;
            ex_rd_addr_o   <= id_rd_addr_i;
            ex_reg_write_o <= id_reg_write_i & id_valid_i;
        end
    end

    logic exmem_live;
    logic memwb_live;

    // EX/MEM is checked first because it holds the youngest value of a register.
    always_comb begin
        exmem_live  = exmem_reg_write_i && (exmem_rd_addr_i != 5'd0);
        memwb_live  = memwb_reg_write_i && (memwb_rd_addr_i != 5'd0);
        fwd_a_sel_o = SEL_REG;
        fwd_b_sel_o = SEL_REG;
        if (ex_valid_o) begin
            if (exmem_live && (exmem_rd_addr_i == ex_rs_addr_o))
                fwd_a_sel_o = SEL_EXMEM;
            else if (memwb_live && (memwb_rd_addr_i == ex_rs_addr_o))
                fwd_a_sel_o = SEL_MEMWB;
            if (exmem_live && (exmem_rd_addr_i == ex_rt_addr_o))
                fwd_b_sel_o = SEL_EXMEM;
            else if (memwb_live && (memwb_rd_addr_i == ex_rt_addr_o))
                fwd_b_sel_o = SEL_MEMWB;
        end
    end

`ifdef EX_FWD_COUNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            fwd_cnt_o <= '0;
        else if (ex_valid_o && !stall_i && ((fwd_a_sel_o != SEL_REG) || (fwd_b_sel_o != SEL_REG))
                 && (fwd_cnt_o != 32'hFFFF_FFFF))
            fwd_cnt_o <= fwd_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Self-checking bench for id_ex_forward_stage: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the pipeline slot.
module tb_id_ex_forward_stage;
    localparam int size = 32;

    logic            clk_i = 1'b0;
    logic            rst_i, stall_i, flush_i, id_valid_i, id_reg_write_i;
    logic [size-1:0] id_rs_data_i, id_rt_data_i;
    logic [4:0]      id_rs_addr_i, id_rt_addr_i, id_rd_addr_i;
    logic            exmem_reg_write_i, memwb_reg_write_i;
    logic [4:0]      exmem_rd_addr_i, memwb_rd_addr_i;
    logic            ex_valid_o, ex_reg_write_o;
    logic [size-1:0] ex_rs_data_o, ex_rt_data_o;
    logic [4:0]      ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o;
    logic [1:0]      fwd_a_sel_o, fwd_b_sel_o;
`ifdef EX_FWD_COUNT_EN
    logic [31:0]     fwd_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural picture of what the EX slot should hold
    logic            modelKnown = 1'b0;
    logic            mValid, mWrite;
    logic [size-1:0] mRsData, mRtData;
    logic [4:0]      mRs, mRt, mRd;
    logic [31:0]     mCnt;

    always #5 clk_i = ~clk_i;

    id_ex_forward_stage #(.size(size)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
        .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i),
        .id_reg_write_i(id_reg_write_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_addr_i(exmem_rd_addr_i),
        .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_addr_i(memwb_rd_addr_i),
        .ex_valid_o(ex_valid_o), .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
        .ex_rs_addr_o(ex_rs_addr_o), .ex_rt_addr_o(ex_rt_addr_o), .ex_rd_addr_o(ex_rd_addr_o),
        .ex_reg_write_o(ex_reg_write_o), .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o)
`ifdef EX_FWD_COUNT_EN
        , .fwd_cnt_o(fwd_cnt_o)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Which source should feed an operand whose register number is src
    function automatic logic [1:0] refSel(input logic [4:0] src);
        if (!mValid) return 2'd0;
        if (exmem_reg_write_i && exmem_rd_addr_i != 5'd0 && exmem_rd_addr_i == src) return 2'd2;
        if (memwb_reg_write_i && memwb_rd_addr_i != 5'd0 && memwb_rd_addr_i == src) return 2'd1;
        return 2'd0;
    endfunction

    task automatic checkAll();
        if (modelKnown) begin
            checkOutput("ex_valid", 32'(ex_valid_o), 32'(mValid));
            checkOutput("ex_rs_data", 32'(ex_rs_data_o), 32'(mRsData));
            checkOutput("ex_rt_data", 32'(ex_rt_data_o), 32'(mRtData));
            checkOutput("ex_rs_addr", 32'(ex_rs_addr_o), 32'(mRs));
            checkOutput("ex_rt_addr", 32'(ex_rt_addr_o), 32'(mRt));
            checkOutput("ex_rd_addr", 32'(ex_rd_addr_o), 32'(mRd));
            checkOutput("ex_reg_write", 32'(ex_reg_write_o), 32'(mWrite));
            checkOutput("fwd_a_sel", 32'(fwd_a_sel_o), 32'(refSel(mRs)));
            checkOutput("fwd_b_sel", 32'(fwd_b_sel_o), 32'(refSel(mRt)));
`ifdef EX_FWD_COUNT_EN
            checkOutput("fwd_cnt", fwd_cnt_o, mCnt);
`endif
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic stall, input logic flush,
                                 input logic valid, input logic wr,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [size-1:0] rsData, input logic [size-1:0] rtData,
                                 input logic xw, input logic [4:0] xrd,
                                 input logic ww, input logic [4:0] wrd);
        @(negedge clk_i);
        rst_i = rst; stall_i = stall; flush_i = flush;
        id_valid_i = valid; id_reg_write_i = wr;
        id_rs_addr_i = rs; id_rt_addr_i = rt; id_rd_addr_i = rd;
        id_rs_data_i = rsData; id_rt_data_i = rtData;
        exmem_reg_write_i = xw; exmem_rd_addr_i = xrd;
        memwb_reg_write_i = ww; memwb_rd_addr_i = wrd;
        #1;
        checkAll();
    endtask

    // Advance the model across the coming rising edge, then let the edge happen
    task automatic tick();
        if (rst_i) begin
            mValid = 0; mWrite = 0; mRsData = '0; mRtData = '0;
            mRs = '0; mRt = '0; mRd = '0; mCnt = '0;
            modelKnown = 1'b1;
        end else begin
            if (mValid && !stall_i && (refSel(mRs) != 2'd0 || refSel(mRt) != 2'd0) && mCnt != 32'hFFFF_FFFF)
                mCnt = mCnt + 32'd1;
            if (flush_i) begin
                mValid = 0; mWrite = 0; mRsData = '0; mRtData = '0;
                mRs = '0; mRt = '0; mRd = '0;
            end else if (!stall_i) begin
                mValid = id_valid_i; mWrite = id_reg_write_i && id_valid_i;
                mRsData = id_rs_data_i; mRtData = id_rt_data_i;
                mRs = id_rs_addr_i; mRt = id_rt_addr_i; mRd = id_rd_addr_i;
            end
        end
        @(posedge clk_i);
    endtask

    initial begin
        // T1: reset held two cycles while ID presents a live instruction
        applyStimulus(1, 0, 0, 1, 1, 5'd3, 5'd4, 5'd5, 32'hAAAA, 32'hBBBB, 1, 5'd3, 1, 5'd4); tick();
        applyStimulus(1, 0, 0, 1, 1, 5'd3, 5'd4, 5'd5, 32'hAAAA, 32'hBBBB, 1, 5'd3, 1, 5'd4); tick();
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, '0, '0, 1, 5'd3, 1, 5'd4);
        checkOutput("T1_valid", 32'(ex_valid_o), 32'd0);
        checkOutput("T1_rs_data", ex_rs_data_o, 32'd0);
        checkOutput("T1_sel_a", 32'(fwd_a_sel_o), 32'd0);
        checkOutput("T1_sel_b", 32'(fwd_b_sel_o), 32'd0);
        tick();

        // T2: EX/MEM forward to operand A only
        applyStimulus(0, 0, 0, 1, 1, 5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 0, 5'd0, 0, 5'd0); tick();
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, '0, '0, 1, 5'd5, 0, 5'd0);
        checkOutput("T2_sel_a", 32'(fwd_a_sel_o), 32'd2);
        checkOutput("T2_sel_b", 32'(fwd_b_sel_o), 32'd0);
        tick();

        // T3: both stages match, EX/MEM wins; then MEM/WB alone
        applyStimulus(0, 0, 0, 1, 1, 5'd7, 5'd7, 5'd9, 32'h33, 32'h44, 0, 5'd0, 0, 5'd0); tick();
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, '0, '0, 1, 5'd7, 1, 5'd7);
        checkOutput("T3_both_a", 32'(fwd_a_sel_o), 32'd2);
        checkOutput("T3_both_b", 32'(fwd_b_sel_o), 32'd2);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, '0, '0, 0, 5'd7, 1, 5'd7);
        checkOutput("T3_memwb_a", 32'(fwd_a_sel_o), 32'd1);
        checkOutput("T3_memwb_b", 32'(fwd_b_sel_o), 32'd1);
        tick();

        // T4: register zero is never forwarded
        applyStimulus(0, 0, 0, 1, 1, 5'd0, 5'd3, 5'd1, 32'h55, 32'h66, 0, 5'd0, 0, 5'd0); tick();
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, '0, '0, 1, 5'd0, 1, 5'd0);
        checkOutput("T4_zero_a", 32'(fwd_a_sel_o), 32'd0);
        tick();

        // T5: stall holds captured data, flush beats stall
        applyStimulus(0, 0, 0, 1, 1, 5'd9, 5'd2, 5'd4, 32'h1234, 32'h77, 0, 5'd0, 0, 5'd0); tick();
        applyStimulus(0, 1, 0, 1, 1, 5'd1, 5'd1, 5'd1, 32'hDEAD, 32'hBEEF, 0, 5'd0, 0, 5'd0); tick();
        applyStimulus(0, 1, 1, 1, 1, 5'd1, 5'd1, 5'd1, 32'hDEAD, 32'hBEEF, 0, 5'd0, 0, 5'd0);
        checkOutput("T5_stall_data", ex_rs_data_o, 32'h1234);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, '0, '0, 1, 5'd9, 1, 5'd2);
        checkOutput("T5_flush_valid", 32'(ex_valid_o), 32'd0);
        checkOutput("T5_flush_sel_a", 32'(fwd_a_sel_o), 32'd0);
        checkOutput("T5_flush_sel_b", 32'(fwd_b_sel_o), 32'd0);
        tick();

`ifdef EX_FWD_COUNT_EN
        // T6: three forwarding cycles, the middle one stalled
        applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, '0, '0, 0, 5'd0, 0, 5'd0); tick();
        applyStimulus(0, 0, 0, 1, 1, 5'd4, 5'd2, 5'd6, 32'h1, 32'h2, 0, 5'd0, 0, 5'd0); tick();
        applyStimulus(0, 0, 0, 1, 1, 5'd4, 5'd2, 5'd6, 32'h1, 32'h2, 1, 5'd4, 0, 5'd0); tick();
        applyStimulus(0, 1, 0, 1, 1, 5'd4, 5'd2, 5'd6, 32'h1, 32'h2, 1, 5'd4, 0, 5'd0); tick();
        applyStimulus(0, 0, 0, 1, 1, 5'd4, 5'd2, 5'd6, 32'h1, 32'h2, 1, 5'd4, 0, 5'd0); tick();
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, '0, '0, 0, 5'd0, 0, 5'd0);
        checkOutput("T6_count", fwd_cnt_o, 32'd2);
        tick();
`endif

        // Random traffic on a small register window so matches are frequent
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                          $urandom, $urandom,
                          1'($urandom), 5'($urandom_range(0, 3)),
                          1'($urandom), 5'($urandom_range(0, 3)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
